// File: rtl/rf_param.sv
// Parametrised multi-port register file with registered reads, optional
// write-to-read bypass and a per-register busy scoreboard for hazard detection.
module rf_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         read_enabled,
  input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
  output logic [NUM_READ*DATA_W-1:0]   read_data,
  output logic [NUM_READ-1:0]          read_busy,
  input  logic                         write_enabled,
  input  logic [ADDR_W-1:0]            write_addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         reserve_enabled,
  input  logic [ADDR_W-1:0]            reserve_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [DATA_W-1:0]          mem_d [DEPTH];
  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [NUM_READ*DATA_W-1:0] read_data_q, read_data_d;
  logic [NUM_READ-1:0]        read_busy_q, read_busy_d;
  logic                       write_ok, reserve_ok;

  // Register 0 neither accepts writes nor reservations when hardwired to zero.
  always_comb begin
    write_ok   = write_enabled   && !((ZERO_REG != 0) && (write_addr == '0));
    reserve_ok = reserve_enabled && !((ZERO_REG != 0) && (reserve_addr == '0));
  end

  // Reserve is applied after the write clear so a new producer wins the busy bit.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (write_ok) begin
      mem_d[write_addr]  = write_data;
      busy_d[write_addr] = 1'b0;
    end
    if (reserve_ok) begin
      busy_d[reserve_addr] = 1'b1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    addr        = '0;
    read_data_d = read_data_q;
    read_busy_d = read_busy_q;
    if (read_enabled) begin
      for (int k = 0; k < NUM_READ; k++) begin
        addr = read_addr[k*ADDR_W +: ADDR_W];
        if ((ZERO_REG != 0) && (addr == '0)) begin
          read_data_d[k*DATA_W +: DATA_W] = '0;
          read_busy_d[k]                  = 1'b0;
        end else if (write_ok && (write_addr == addr)) begin
          // A same-cycle write always clears busy; only the data depends on bypass.
          read_data_d[k*DATA_W +: DATA_W] = (BYPASS != 0) ? write_data : mem_q[addr];
          read_busy_d[k]                  = 1'b0;
        end else begin
          read_data_d[k*DATA_W +: DATA_W] = mem_q[addr];
          read_busy_d[k]                  = busy_q[addr];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q      <= '0;
      read_data_q <= '0;
      read_busy_q <= '0;
    end else begin
      mem_q       <= mem_d;
      busy_q      <= busy_d;
      read_data_q <= read_data_d;
      read_busy_q <= read_busy_d;
    end
  end

  assign read_data = read_data_q;
  assign read_busy = read_busy_q;

endmodule

// File: tb/tb_rf_param.sv
// Scoreboard bench for rf_param: a default instance (32x32, 2 ports, bypass,
// zero register) and a small one (8x16, 4 ports, no bypass, r0 writable).
module tb_rf_param;

  typedef struct {
    logic       re;
    logic [4:0] ra [4];
    logic       we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic       rese;
    logic [4:0] resa;
  } stim_t;

  typedef struct {
    logic [31:0] d [8];
    logic        b [8];
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        readEnA, writeEnA, resEnA;
  logic [9:0]  readAddrA;
  logic [63:0] readDataA;
  logic [1:0]  readBusyA;
  logic [4:0]  writeAddrA, resAddrA;
  logic [31:0] writeDataA;

  logic        readEnB, writeEnB, resEnB;
  logic [11:0] readAddrB;
  logic [63:0] readDataB;
  logic [3:0]  readBusyB;
  logic [2:0]  writeAddrB, resAddrB;
  logic [15:0] writeDataB;

  rf_param dutA (
    .clock(clock), .reset(reset), .read_enabled(readEnA), .read_addr(readAddrA),
    .read_data(readDataA), .read_busy(readBusyA), .write_enabled(writeEnA),
    .write_addr(writeAddrA), .write_data(writeDataA), .reserve_enabled(resEnA),
    .reserve_addr(resAddrA)
  );

  rf_param #(.DATA_W(16), .ADDR_W(3), .NUM_READ(4), .BYPASS(0), .ZERO_REG(0)) dutB (
    .clock(clock), .reset(reset), .read_enabled(readEnB), .read_addr(readAddrB),
    .read_data(readDataB), .read_busy(readBusyB), .write_enabled(writeEnB),
    .write_addr(writeAddrB), .write_data(writeDataB), .reserve_enabled(resEnB),
    .reserve_addr(resAddrB)
  );

  // Reference model: contents, busy flags and last captured read results.
  logic [31:0] mMem  [2][32];
  logic        mBusy [2][32];
  logic [31:0] mOutD [8];
  logic        mOutB [8];

  stim_t st [2];
  exp_t  expQ [$];
  int    nVectors = 0;
  int    nFails   = 0;
  bit    monOn    = 0;

  function automatic int numPorts(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.re = 0; s.we = 0; s.wa = 0; s.wd = 0; s.rese = 0; s.resa = 0;
    for (int k = 0; k < 4; k++) s.ra[k] = 0;
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) begin
        mMem[i][a]  = 0;
        mBusy[i][a] = 0;
      end
    for (int j = 0; j < 8; j++) begin
      mOutD[j] = 0;
      mOutB[j] = 0;
    end
  endtask

  // Reads see the pre-edge file; a same-edge write clears busy and, with bypass,
  // supplies the data; the hardwired zero register overrides everything.
  task automatic modelStep(input int i);
    int          depth   = (i == 0) ? 32 : 8;
    logic [31:0] dmask   = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    bit          bypass  = (i == 0);
    bit          zeroReg = (i == 0);
    int          wa      = int'(st[i].wa) % depth;
    int          resa    = int'(st[i].resa) % depth;
    logic [31:0] wd      = st[i].wd & dmask;
    bit          writes  = st[i].we   && !(zeroReg && wa == 0);
    bit          reserves = st[i].rese && !(zeroReg && resa == 0);
    if (st[i].re) begin
      for (int k = 0; k < numPorts(i); k++) begin
        int a = int'(st[i].ra[k]) % depth;
        logic [31:0] v = mMem[i][a];
        logic        b = mBusy[i][a];
        if (writes && wa == a) begin
          b = 0;
          if (bypass) v = wd;
        end
        if (zeroReg && a == 0) begin
          v = 0;
          b = 0;
        end
        mOutD[i*4+k] = v;
        mOutB[i*4+k] = b;
      end
    end
    if (writes) begin
      mMem[i][wa]  = wd;
      mBusy[i][wa] = 0;
    end
    if (reserves) mBusy[i][resa] = 1;
  endtask

  task automatic drivePins();
    readEnA    = st[0].re;
    writeEnA   = st[0].we;
    writeAddrA = st[0].wa;
    writeDataA = st[0].wd;
    resEnA     = st[0].rese;
    resAddrA   = st[0].resa;
    for (int k = 0; k < 2; k++) readAddrA[k*5 +: 5] = st[0].ra[k];
    readEnB    = st[1].re;
    writeEnB   = st[1].we;
    writeAddrB = st[1].wa[2:0];
    writeDataB = st[1].wd[15:0];
    resEnB     = st[1].rese;
    resAddrB   = st[1].resa[2:0];
    for (int k = 0; k < 4; k++) readAddrB[k*3 +: 3] = st[1].ra[k][2:0];
  endtask

  task automatic applyStimulus();
    exp_t e;
    @(negedge clock);
    drivePins();
    modelStep(0);
    modelStep(1);
    for (int j = 0; j < 8; j++) begin
      e.d[j] = mOutD[j];
      e.b[j] = mOutB[j];
    end
    expQ.push_back(e);
    monOn = 1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      nVectors++;
      nFails++;
      $display("[TB] FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
      return;
    end
    e = expQ.pop_front();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < numPorts(i); k++) begin
        logic [31:0] d;
        logic        b;
        d = (i == 0) ? readDataA[k*32 +: 32] : {16'h0, readDataB[k*16 +: 16]};
        b = (i == 0) ? readBusyA[k] : readBusyB[k];
        nVectors++;
        if (d !== e.d[i*4+k] || b !== e.b[i*4+k]) begin
          nFails++;
          $display("[TB] FAIL read_dut%0d_port%0d at %0t: got data %h busy %b, required data %h busy %b",
                   i, k, $time, d, b, e.d[i*4+k], e.b[i*4+k]);
        end
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    nVectors++;
    if (readDataA !== 64'h0 || readBusyA !== 2'b0 || readDataB !== 64'h0 || readBusyB !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL %s: got A %h/%b B %h/%b, required all zero",
               tag, readDataA, readBusyA, readDataB, readBusyB);
    end
  endtask

  // Monitor: consumes one expectation per edge while the scoreboard is armed.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (monOn) checkOutput();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic readAll(input logic [4:0] a);
    for (int i = 0; i < 2; i++) begin
      st[i].re = 1;
      for (int k = 0; k < 4; k++) st[i].ra[k] = a;
    end
  endtask

  task automatic writeBoth(input logic [4:0] a, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      st[i].we = 1;
      st[i].wa = a;
      st[i].wd = d;
    end
  endtask

  task automatic reserveBoth(input logic [4:0] a);
    for (int i = 0; i < 2; i++) begin
      st[i].rese = 1;
      st[i].resa = a;
    end
  endtask

  task automatic idleBoth();
    st[0] = idleStim();
    st[1] = idleStim();
  endtask

  initial begin
    modelReset();
    idleBoth();
    drivePins();
    #2;
    checkResetOutputs("reset_initial");
    @(negedge clock);
    @(negedge clock);
    reset = 0;

    // Fill: A gets r1..r31, B gets r1..r7 of its 8 registers.
    for (int i = 1; i < 32; i++) begin
      idleBoth();
      st[0].we = 1; st[0].wa = 5'(i);
      st[0].wd = (i == 31) ? 32'hDEAD_BEEF : 32'h1111_1111 * i;
      if (i < 8) begin
        st[1].we = 1; st[1].wa = 5'(i); st[1].wd = 32'h1111 * i;
      end
      applyStimulus();
    end
    for (int a = 0; a < 32; a++) begin
      idleBoth();
      st[0].re = 1; st[0].ra[0] = 5'(a); st[0].ra[1] = 5'(a);
      st[1].re = 1;
      for (int k = 0; k < 4; k++) st[1].ra[k] = 5'((a + k) % 8);
      applyStimulus();
    end

    // Zero register: write and reserve r0, read it this cycle and the next.
    idleBoth(); writeBoth(0, 32'hDEAD_BEEF); reserveBoth(0); readAll(0); applyStimulus();
    idleBoth(); readAll(0); applyStimulus();

    // Bypass: r7 holds 0x66666666, overwritten while being read.
    idleBoth(); writeBoth(7, 32'h6666_6666); applyStimulus();
    idleBoth(); writeBoth(7, 32'hCAFE_F00D); readAll(7); applyStimulus();
    idleBoth(); readAll(7); applyStimulus();

    // Busy scoreboard on r9 (r1 in the 8-entry file).
    idleBoth(); reserveBoth(9); readAll(9); applyStimulus();
    idleBoth(); readAll(9); applyStimulus();
    idleBoth(); writeBoth(9, 32'h0BAD_F00D); readAll(9); applyStimulus();
    idleBoth(); writeBoth(9, 32'h1234_5678); reserveBoth(9); readAll(9); applyStimulus();
    idleBoth(); readAll(9); applyStimulus();

    // Hold: memory and addresses change while reads are disabled.
    for (int n = 0; n < 6; n++) begin
      idleBoth();
      for (int i = 0; i < 2; i++) begin
        st[i].we = 1; st[i].wa = 5'($urandom_range(0, 7)); st[i].wd = $urandom;
        st[i].rese = 1; st[i].resa = 5'($urandom_range(0, 7));
        for (int k = 0; k < 4; k++) st[i].ra[k] = 5'($urandom);
      end
      applyStimulus();
    end

    // Randomised traffic, biased to a few addresses to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        bit narrow = ($urandom_range(0, 1) == 1);
        st[i].re   = ($urandom_range(0, 3) != 0);
        st[i].we   = ($urandom_range(0, 2) != 0);
        st[i].rese = ($urandom_range(0, 2) == 0);
        st[i].wa   = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        st[i].resa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        st[i].wd   = $urandom;
        for (int k = 0; k < 4; k++)
          st[i].ra[k] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      end
      applyStimulus();
    end

    // Mid-cycle reset right after a write and reserve, with another write pending.
    idleBoth(); writeBoth(5, 32'hDEAD_BEEF); reserveBoth(6); readAll(5); applyStimulus();
    @(negedge clock);
    monOn = 0;
    idleBoth(); writeBoth(5, 32'h1234_5678); readAll(5);
    drivePins();
    #2;
    reset = 1;
    #1;
    checkResetOutputs("reset_async_assert");
    @(negedge clock);
    checkResetOutputs("reset_held_over_edge");
    modelReset();
    idleBoth();
    drivePins();
    reset = 0;
    idleBoth(); readAll(5); applyStimulus();
    idleBoth(); readAll(6); applyStimulus();
    idleBoth(); st[0].re = 1; st[0].ra[0] = 31; st[0].ra[1] = 1;
    st[1].re = 1; for (int k = 0; k < 4; k++) st[1].ra[k] = 5'(k + 4);
    applyStimulus();

    @(negedge clock);
    monOn = 0;
    nVectors++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule
